pipeline_hazard_controller: RTL and testbench

- Central hazard and sequencing controller for the 5-stage RV32I pipeline.
- Drives the EX-stage operand forwarding muxes using the 2-bit forwarding encoding: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- Detects load-use hazards and taken-branch flushes, and freezes the whole pipeline while the data-memory handshake is outstanding.
- Keeps a memory-timeout watchdog and saturating performance counters.

---
 rtl/pipeline_hazard_controller_if.sv | 81 ++++++++
 rtl/pipeline_hazard_controller.sv | 182 ++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller_if
//
// Bundles every pipeline-facing signal of the hazard controller so that the
// datapath and the controller can be wired together with a single port.
//
// Parameters:
//   CNT_W            width of the performance counters
//
// Signals (direction seen from the controller, modport slave):
//   id_rs1, id_rs2           in   source registers of the instruction in ID
//   id_uses_rs1, id_uses_rs2 in   ID instruction really reads rs1 / rs2
//   ex_rs1, ex_rs2           in   source registers of the instruction in EX
//   ex_rd                    in   destination register in EX
//   ex_mem_read              in   instruction in EX is a load
//   ex_branch_taken          in   branch/jump resolved taken in EX
//   mem_rd, mem_reg_write    in   destination / write enable in MEM
//   wb_rd, wb_reg_write      in   destination / write enable in WB
//   dmem_req, dmem_ready     in   data-memory handshake
//   forward_a, forward_b     out  ALU operand source selects
//   pc_write, if_id_write    out  front-end update enables
//   if_id_flush              out  IF/ID loads a NOP
//   id_ex_bubble             out  ID/EX loads a NOP
//   pipe_freeze              out  back-end registers hold
//   mem_wb_bubble            out  suppress WB write while frozen
//   mem_timeout              out  sticky memory-timeout flag
//   stall_cycles             out  stall cycle counter
//   flush_count              out  branch flush counter
// ---------------------------------------------------------------------------
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic [4:0]       wb_rd;
    logic             wb_reg_write;
    logic             dmem_req;
    logic             dmem_ready;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pipe_freeze;
    logic             mem_wb_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    // The controller consumes pipeline status and produces control.
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch_taken,
        input  mem_rd, mem_reg_write, wb_rd, wb_reg_write,
        input  dmem_req, dmem_ready,
        output forward_a, forward_b, pc_write, if_id_write, if_id_flush,
        output id_ex_bubble, pipe_freeze, mem_wb_bubble, mem_timeout,
        output stall_cycles, flush_count
    );

    // The pipeline datapath reports status and obeys control.
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch_taken,
        output mem_rd, mem_reg_write, wb_rd, wb_reg_write,
        output dmem_req, dmem_ready,
        input  forward_a, forward_b, pc_write, if_id_write, if_id_flush,
        input  id_ex_bubble, pipe_freeze, mem_wb_bubble, mem_timeout,
        input  stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Central hazard and sequencing controller for the 5-stage RV32I pipeline:
// operand forwarding selects, load-use stalls, taken-branch flushes, a full
// pipeline freeze while a data-memory access is outstanding, a memory
// timeout watchdog and saturating performance counters.
//
// Parameters:
//   TIMEOUT_CYCLES   consecutive frozen cycles that raise mem_timeout
//   CNT_W            performance counter width
//
// Ports:
//   clk      pipeline clock
//   reset    asynchronous active-high reset
//   hz       pipeline_hazard_controller_if.slave, all status and control
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    pipeline_hazard_controller_if.slave   hz
);

    localparam int                WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

    typedef enum logic {
        RUN,
        WAIT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_next;

    logic               freeze;
    logic               load_use_hazard;
    logic               branch_flush;
    logic               lu_stall;
    logic               lu_done;
    logic               timeout_flag;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    // Forwarding source for one ALU operand. The youngest producer (EX/MEM)
    // wins over MEM/WB, and x0 is never forwarded because it reads as zero.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic       mem_wr,
        input logic [4:0] mem_dst,
        input logic       wb_wr,
        input logic [4:0] wb_dst
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_wr && (mem_dst != 5'd0) && (mem_dst == rs)) begin
            sel = 2'b10;
        end else if (wb_wr && (wb_dst != 5'd0) && (wb_dst == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Event decoding with the priority freeze > branch > load-use. The
    // lu_done term keeps a load-use stall to exactly one bubble even if the
    // hazard inputs stay asserted in the following cycle.
    always_comb begin
        freeze          = hz.dmem_req && !hz.dmem_ready;
        load_use_hazard = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                          ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                           (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
        branch_flush    = !freeze && hz.ex_branch_taken;
        lu_stall        = !freeze && !hz.ex_branch_taken &&
                          load_use_hazard && !lu_done;
    end

    // Pipeline control outputs. Everything here is combinational, so reset
    // forces the reset values directly to make them take effect without
    // waiting for a clock edge, even while a freeze is being requested.
    always_comb begin
        hz.forward_a     = fwd_select(hz.ex_rs1, hz.mem_reg_write, hz.mem_rd,
                                      hz.wb_reg_write, hz.wb_rd);
        hz.forward_b     = fwd_select(hz.ex_rs2, hz.mem_reg_write, hz.mem_rd,
                                      hz.wb_reg_write, hz.wb_rd);
        hz.pc_write      = !freeze && !lu_stall;
        hz.if_id_write   = !freeze && !lu_stall;
        hz.if_id_flush   = branch_flush;
        hz.id_ex_bubble  = branch_flush || lu_stall;
        hz.pipe_freeze   = freeze;
        hz.mem_wb_bubble = freeze;
        if (reset) begin
            hz.forward_a     = 2'b00;
            hz.forward_b     = 2'b00;
            hz.pc_write      = 1'b1;
            hz.if_id_write   = 1'b1;
            hz.if_id_flush   = 1'b0;
            hz.id_ex_bubble  = 1'b0;
            hz.pipe_freeze   = 1'b0;
            hz.mem_wb_bubble = 1'b0;
        end
    end

    // Memory-wait FSM next state. wait_cnt counts the frozen cycles seen so
    // far in the current freeze and saturates at TIMEOUT_CYCLES so it never
    // wraps back below the watchdog threshold.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        case (state)
            RUN: begin
                if (freeze) begin
                    state_next = WAIT;
                    wait_next  = WAIT_W'(1);
                end
            end
            WAIT: begin
                if (!freeze) begin
                    state_next = RUN;
                    wait_next  = '0;
                end else if (wait_cnt != WAIT_MAX) begin
                    wait_next  = wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                state_next = RUN;
                wait_next  = '0;
            end
        endcase
    end

    // Memory-wait FSM registers and the sticky watchdog flag. The flag sets
    // one edge after the count reaches the threshold and only reset clears
    // it; the freeze itself keeps going for as long as memory holds off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (wait_cnt == WAIT_MAX) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    // One-cycle memory of a load-use stall so the same hazard cannot stall
    // twice in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lu_done <= 1'b0;
        end else begin
            lu_done <= lu_stall;
        end
    end

    // Saturating performance counters: they stick at all-ones rather than
    // wrapping so a long run never reports a misleadingly small value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((freeze || lu_stall) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (branch_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.mem_timeout  = timeout_flag;
    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_count  = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_controller
//
// Self-checking bench for pipeline_hazard_controller. Small TIMEOUT_CYCLES
// and CNT_W make the watchdog and counter saturation reachable quickly.
// Inputs change on the falling edge; outputs are sampled 1 ns later, well
// away from the rising edge that updates the controller state.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

    localparam int TIMEOUT = 4;
    localparam int CW      = 4;
    localparam int CMAX    = (1 << CW) - 1;

    typedef struct {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_uses_rs1;
        logic       id_uses_rs2;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_mem_read;
        logic       ex_branch_taken;
        logic [4:0] mem_rd;
        logic       mem_reg_write;
        logic [4:0] wb_rd;
        logic       wb_reg_write;
        logic       dmem_req;
        logic       dmem_ready;
    } stim_t;

    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state, kept in terms of observable pipeline events.
    int m_stall;
    int m_flush;
    int m_frozen_run;
    bit m_timeout;
    bit m_stalled_last;

    pipeline_hazard_controller_if #(.CNT_W(CW)) hz_if ();

    pipeline_hazard_controller #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Single comparison point: count it and report any difference.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Forwarding reference: scan producers from youngest to oldest and take
    // the first one that writes the wanted non-zero register.
    function automatic logic [1:0] fwdModel(input logic [4:0] rs, input stim_t s);
        logic [4:0] dst  [2];
        logic       wr   [2];
        logic [1:0] code [2];
        dst[0] = s.mem_rd; wr[0] = s.mem_reg_write; code[0] = 2'b10;
        dst[1] = s.wb_rd;  wr[1] = s.wb_reg_write;  code[1] = 2'b01;
        for (int i = 0; i < 2; i++) begin
            if (wr[i] && rs != 0 && dst[i] == rs) return code[i];
        end
        return 2'b00;
    endfunction

    function automatic int satInc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic driveInputs(input stim_t s);
        hz_if.id_rs1          = s.id_rs1;
        hz_if.id_rs2          = s.id_rs2;
        hz_if.id_uses_rs1     = s.id_uses_rs1;
        hz_if.id_uses_rs2     = s.id_uses_rs2;
        hz_if.ex_rs1          = s.ex_rs1;
        hz_if.ex_rs2          = s.ex_rs2;
        hz_if.ex_rd           = s.ex_rd;
        hz_if.ex_mem_read     = s.ex_mem_read;
        hz_if.ex_branch_taken = s.ex_branch_taken;
        hz_if.mem_rd          = s.mem_rd;
        hz_if.mem_reg_write   = s.mem_reg_write;
        hz_if.wb_rd           = s.wb_rd;
        hz_if.wb_reg_write    = s.wb_reg_write;
        hz_if.dmem_req        = s.dmem_req;
        hz_if.dmem_ready      = s.dmem_ready;
    endtask

    // Compare every output against the model for the current cycle, then
    // advance the model across the coming rising edge.
    task automatic checkCycle(input stim_t s);
        bit frozen, hazard, flush, stall;
        frozen = s.dmem_req && !s.dmem_ready;
        hazard = s.ex_mem_read && s.ex_rd != 0 &&
                 ((s.id_uses_rs1 && s.id_rs1 == s.ex_rd) ||
                  (s.id_uses_rs2 && s.id_rs2 == s.ex_rd));
        flush  = !frozen && s.ex_branch_taken;
        stall  = !frozen && !s.ex_branch_taken && hazard && !m_stalled_last;

        checkOutput("forward_a",     hz_if.forward_a,     fwdModel(s.ex_rs1, s));
        checkOutput("forward_b",     hz_if.forward_b,     fwdModel(s.ex_rs2, s));
        checkOutput("pc_write",      hz_if.pc_write,      !(frozen || stall));
        checkOutput("if_id_write",   hz_if.if_id_write,   !(frozen || stall));
        checkOutput("if_id_flush",   hz_if.if_id_flush,   flush);
        checkOutput("id_ex_bubble",  hz_if.id_ex_bubble,  flush || stall);
        checkOutput("pipe_freeze",   hz_if.pipe_freeze,   frozen);
        checkOutput("mem_wb_bubble", hz_if.mem_wb_bubble, frozen);
        checkOutput("mem_timeout",   hz_if.mem_timeout,   m_timeout);
        checkOutput("stall_cycles",  hz_if.stall_cycles,  m_stall);
        checkOutput("flush_count",   hz_if.flush_count,   m_flush);

        if (m_frozen_run >= TIMEOUT) m_timeout = 1'b1;
        m_frozen_run   = frozen ? m_frozen_run + 1 : 0;
        if (frozen || stall) m_stall = satInc(m_stall);
        if (flush)           m_flush = satInc(m_flush);
        m_stalled_last = stall;
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        driveInputs(s);
        #1;
        checkCycle(s);
    endtask

    // Assert reset with whatever inputs are currently applied and check the
    // outputs settle to reset values before any clock edge.
    task automatic resetDut();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rst_forward_a",     hz_if.forward_a,     2'b00);
        checkOutput("rst_forward_b",     hz_if.forward_b,     2'b00);
        checkOutput("rst_pc_write",      hz_if.pc_write,      1);
        checkOutput("rst_if_id_write",   hz_if.if_id_write,   1);
        checkOutput("rst_if_id_flush",   hz_if.if_id_flush,   0);
        checkOutput("rst_id_ex_bubble",  hz_if.id_ex_bubble,  0);
        checkOutput("rst_pipe_freeze",   hz_if.pipe_freeze,   0);
        checkOutput("rst_mem_wb_bubble", hz_if.mem_wb_bubble, 0);
        checkOutput("rst_mem_timeout",   hz_if.mem_timeout,   0);
        checkOutput("rst_stall_cycles",  hz_if.stall_cycles,  0);
        checkOutput("rst_flush_count",   hz_if.flush_count,   0);
        m_stall        = 0;
        m_flush        = 0;
        m_frozen_run   = 0;
        m_timeout      = 1'b0;
        m_stalled_last = 1'b0;
        @(negedge clk);
        driveInputs(idleStim());
        reset = 1'b0;
    endtask

    function automatic stim_t randomStim();
        stim_t s;
        s.id_rs1          = 5'($urandom_range(0, 3));
        s.id_rs2          = 5'($urandom_range(0, 3));
        s.id_uses_rs1     = 1'($urandom_range(0, 1));
        s.id_uses_rs2     = 1'($urandom_range(0, 1));
        s.ex_rs1          = 5'($urandom_range(0, 3));
        s.ex_rs2          = 5'($urandom_range(0, 3));
        s.ex_rd           = 5'($urandom_range(0, 3));
        s.ex_mem_read     = 1'($urandom_range(0, 1));
        s.ex_branch_taken = 1'($urandom_range(0, 7) == 0);
        s.mem_rd          = 5'($urandom_range(0, 3));
        s.mem_reg_write   = 1'($urandom_range(0, 1));
        s.wb_rd           = 5'($urandom_range(0, 3));
        s.wb_reg_write    = 1'($urandom_range(0, 1));
        s.dmem_req        = 1'($urandom_range(0, 1));
        s.dmem_ready      = 1'($urandom_range(0, 1));
        return s;
    endfunction

    initial begin
        stim_t s;
        reset = 1'b1;
        driveInputs(idleStim());
        resetDut();

        // Forwarding priority and the x0 exclusion.
        s = idleStim();
        s.ex_rs1 = 5'd5;
        s.mem_rd = 5'd5; s.mem_reg_write = 1'b1;
        s.wb_rd  = 5'd5; s.wb_reg_write  = 1'b1;
        applyStimulus(s);
        checkOutput("fwd_exmem", hz_if.forward_a, 2'b10);
        s.mem_reg_write = 1'b0;
        applyStimulus(s);
        checkOutput("fwd_memwb", hz_if.forward_a, 2'b01);
        s.ex_rs1 = 5'd0; s.mem_rd = 5'd0; s.mem_reg_write = 1'b1;
        s.wb_rd  = 5'd0;
        applyStimulus(s);
        checkOutput("fwd_x0", hz_if.forward_a, 2'b00);

        // Load-use on rs2, then the load moves on to MEM.
        resetDut();
        s = idleStim();
        s.ex_mem_read = 1'b1; s.ex_rd = 5'd7;
        s.id_rs2 = 5'd7; s.id_uses_rs2 = 1'b1;
        applyStimulus(s);
        checkOutput("lu_pc_write", hz_if.pc_write,     0);
        checkOutput("lu_bubble",   hz_if.id_ex_bubble, 1);
        s.ex_mem_read = 1'b0; s.ex_rd = 5'd0;
        s.mem_rd = 5'd7; s.mem_reg_write = 1'b1;
        applyStimulus(s);
        checkOutput("lu_released", hz_if.pc_write,     1);
        checkOutput("lu_count",    hz_if.stall_cycles, 1);

        // A hazard held for three cycles stalls, releases, then stalls again.
        s = idleStim();
        s.ex_mem_read = 1'b1; s.ex_rd = 5'd3;
        s.id_rs1 = 5'd3; s.id_uses_rs1 = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(s);

        // Branch overrides a simultaneous load-use hazard.
        resetDut();
        s.ex_branch_taken = 1'b1;
        applyStimulus(s);
        checkOutput("br_flush",    hz_if.if_id_flush,  1);
        checkOutput("br_bubble",   hz_if.id_ex_bubble, 1);
        checkOutput("br_pc_write", hz_if.pc_write,     1);
        applyStimulus(idleStim());
        checkOutput("br_flush_count", hz_if.flush_count,  1);
        checkOutput("br_stall_count", hz_if.stall_cycles, 0);

        // Three frozen cycles followed by the ready cycle.
        resetDut();
        s = idleStim();
        s.dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(s);
            checkOutput("frz_active", hz_if.pipe_freeze, 1);
        end
        s.dmem_ready = 1'b1;
        applyStimulus(s);
        checkOutput("frz_ready", hz_if.pipe_freeze, 0);
        applyStimulus(idleStim());
        checkOutput("frz_count", hz_if.stall_cycles, 3);

        // Watchdog: six frozen cycles with the threshold at four.
        resetDut();
        s = idleStim();
        s.dmem_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(s);
            if (i == 3) checkOutput("tmo_early", hz_if.mem_timeout, 0);
        end
        s.dmem_ready = 1'b1;
        applyStimulus(s);
        checkOutput("tmo_sticky", hz_if.mem_timeout, 1);
        applyStimulus(idleStim());

        // Reset in the middle of a freeze; the wait count must start over.
        resetDut();
        s = idleStim();
        s.dmem_req = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(s);
        s.dmem_ready = 1'b1;
        applyStimulus(s);
        applyStimulus(idleStim());
        checkOutput("rst_frz_timeout", hz_if.mem_timeout, 0);

        // Randomized traffic against the model, with periodic resets.
        for (int blk = 0; blk < 4; blk++) begin
            resetDut();
            for (int i = 0; i < 100; i++) applyStimulus(randomStim());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
